vga_sync_rx: RTL



---
 rtl/vga_sync_rx.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers the raster column/row from an active-low hsync/vsync
// pair clocked on the pixel clock, checks that every sync edge lands where the
// nominal timing places it, and reports horizontal/vertical lock.
// Timing constants are parameters; the defaults describe 640x480 in an
// 800x525 frame.

module vga_sync_rx #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_TOTAL  = 525
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] col,
    output logic [9:0] row,
    output logic       visible,
    output logic       locked,
    output logic       frame_start,
    output logic       sync_err
);

    // Positions where sync edges are expected, as 10-bit counter values.
    localparam logic [9:0] H_ACTIVE_C  = 10'(H_ACTIVE);
    localparam logic [9:0] H_FALL_COL  = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] H_AFTER_COL = 10'(H_ACTIVE + H_FRONT + 1);
    localparam logic [9:0] H_RISE_COL  = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] H_LAST_COL  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_ACTIVE_C  = 10'(V_ACTIVE);
    localparam logic [9:0] V_FALL_ROW  = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] V_RISE_ROW  = 10'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [9:0] V_LAST_ROW  = 10'(V_TOTAL - 1);

    // Registered state
    logic       hs_q, vs_q;
    logic [9:0] col_q, col_d;
    logic [9:0] row_q, row_d;
    logic       h_lock_q, h_lock_d;
    logic       v_lock_q, v_lock_d;
    logic       sync_err_q, sync_err_d;

    // Decoded events
    logic hs_fall, hs_rise, vs_fall, vs_rise;
    logic col_at_fall, col_at_rise, col_at_last, col_at_zero;
    logic v_slot_fall, v_slot_rise;
    logic h_good, h_bad, v_good, v_bad;
    logic h_drop;

    // Previous-cycle sync levels; idle-high after reset so no false edge follows.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q <= 1'b1;
            vs_q <= 1'b1;
        end else begin
            hs_q <= hsync;
            vs_q <= vsync;
        end
    end

    // Edge detection and timing checks, all against the pre-update counters.
    always_comb begin
        hs_fall = hs_q & ~hsync;
        hs_rise = ~hs_q & hsync;
        vs_fall = vs_q & ~vsync;
        vs_rise = ~vs_q & vsync;

        col_at_fall = (col_q == H_FALL_COL);
        col_at_rise = (col_q == H_RISE_COL);
        col_at_last = (col_q == H_LAST_COL);
        col_at_zero = (col_q == 10'd0);

        // Vertical edges are only legal at the start of their line.
        v_slot_fall = (row_q == V_FALL_ROW) & col_at_zero;
        v_slot_rise = (row_q == V_RISE_ROW) & col_at_zero;

        h_good = hs_fall & col_at_fall;
        // Misplaced fall, misplaced rise, or the fall slot passing with no fall.
        h_bad  = (hs_fall & ~col_at_fall)
               | (hs_rise & ~col_at_rise)
               | (col_at_fall & ~hs_fall);

        v_good = vs_fall & v_slot_fall;
        v_bad  = (vs_fall & ~v_slot_fall)
               | (vs_rise & ~v_slot_rise)
               | (v_slot_fall & ~vs_fall);
    end

    // Column/row next state: a sync fall realigns the counter, otherwise free-run.
    always_comb begin
        col_d = col_q;
        row_d = row_q;

        // hsync fall overrides the end-of-line wrap.
        if (hs_fall) begin
            col_d = H_AFTER_COL;
        end else if (col_at_last) begin
            col_d = 10'd0;
        end else begin
            col_d = col_q + 10'd1;
        end

        // vsync fall overrides the line advance; a realigning hsync fall on
        // the last column suppresses the advance because the line did not end.
        if (vs_fall) begin
            row_d = V_FALL_ROW;
        end else if (col_at_last && !hs_fall) begin
            row_d = (row_q == V_LAST_ROW) ? 10'd0 : row_q + 10'd1;
        end
    end

    // Lock next state: a bad event always wins over a coincident good one.
    always_comb begin
        h_lock_d   = h_lock_q;
        v_lock_d   = v_lock_q;
        sync_err_d = 1'b0;

        if (h_bad) begin
            h_lock_d = 1'b0;
        end else if (h_good) begin
            h_lock_d = 1'b1;
        end

        // Losing the line lock invalidates the frame lock as well.
        h_drop = h_lock_q & ~h_lock_d;

        if (v_bad || h_drop) begin
            v_lock_d = 1'b0;
        end else if (v_good) begin
            v_lock_d = 1'b1;
        end

        // Only report errors that break an existing lock; acquisition is silent.
        sync_err_d = (h_bad & h_lock_q) | (v_bad & v_lock_q);
    end

    // Raster counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q <= 10'd0;
            row_q <= 10'd0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Lock state and registered error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_lock_q   <= 1'b0;
            v_lock_q   <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            h_lock_q   <= h_lock_d;
            v_lock_q   <= v_lock_d;
            sync_err_q <= sync_err_d;
        end
    end

    // Status outputs decoded from registered state only.
    always_comb begin
        col         = col_q;
        row         = row_q;
        sync_err    = sync_err_q;
        locked      = h_lock_q & v_lock_q;
        visible     = locked & (col_q < H_ACTIVE_C) & (row_q < V_ACTIVE_C);
        frame_start = locked & col_at_zero & (row_q == 10'd0);
    end

endmodule
